// File: rtl/nios_setup_mul_pkg.sv
// Shared types and constants for the shared-multiplier sequencer.
package nios_setup_mul_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait1,
    StWait2,
    StResp
  } state_e;

  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_MULXUU = 1'b1;

  localparam int unsigned ACC_W  = 64;
  localparam int unsigned PSUM_W = 33;

endpackage

// File: rtl/nios_setup_mul_rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves only when a grant is taken.
module nios_setup_mul_rr_arb2 #(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);

  logic r_ptr;

  always_comb begin
    o_grant     = 2'b00;
    o_grant_idx = r_ptr;
    if (i_en) begin
      unique case (i_req)
        2'b01: begin
          o_grant     = 2'b01;
          o_grant_idx = 1'b0;
        end
        2'b10: begin
          o_grant     = 2'b10;
          o_grant_idx = 1'b1;
        end
        2'b11: begin
          o_grant     = r_ptr ? 2'b10 : 2'b01;
          o_grant_idx = r_ptr;
        end
        default: ;
      endcase
    end
  end

  // A requester that withdraws before winning keeps its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= INIT_PRIO;
    end else if (i_en && (|i_req)) begin
      r_ptr <= ~o_grant_idx;
    end
  end

endmodule

// File: rtl/nios_setup_mul_seq_arb.sv
// Shares one 3-product 16x16 multiplier cell between two requesters and assembles
// the low (MUL) or unsigned high (MULXUU) word of the 32x32 product.
module nios_setup_mul_seq_arb
  import nios_setup_mul_pkg::*;
#(
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_op,
  input  logic [63:0] req_src1,
  input  logic [63:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic [31:0] cell_src1,
  output logic [31:0] cell_src2,
  output logic        cell_en,
  input  logic [31:0] cell_p1,
  input  logic [31:0] cell_p2,
  input  logic [31:0] cell_p3
);

  state_e      r_state, w_state_d;
  logic        r_op, r_id;
  logic [15:0] r_a_hi, r_b_hi;
  logic [31:0] r_acc_hi;
  logic [31:0] r_rsp_data;
  logic [31:0] r_src1, r_src2;

  logic              w_idle_en, w_accept, w_win;
  logic [1:0]        w_grant;
  logic [31:0]       w_win_src1, w_win_src2;
  logic [31:0]       w_src1, w_src2;
  logic [PSUM_W-1:0] w_psum;
  logic [ACC_W-1:0]  w_acc;
  logic [31:0]       w_hi_word;

  // Grants are suppressed while reset is asserted so req_ready reads zero.
  assign w_idle_en = reset_n && (r_state == StIdle);
  assign w_accept  = w_idle_en && (|req_valid);

  nios_setup_mul_rr_arb2 #(
    .INIT_PRIO(INIT_PRIO)
  ) u_arb (
    .clk        (clk),
    .rst_n      (reset_n),
    .i_req      (req_valid),
    .i_en       (w_idle_en),
    .o_grant    (w_grant),
    .o_grant_idx(w_win)
  );

  assign w_win_src1 = w_win ? req_src1[63:32] : req_src1[31:0];
  assign w_win_src2 = w_win ? req_src2[63:32] : req_src2[31:0];

  // p2+p3 keeps its carry; acc is full width so nothing is lost before the select.
  assign w_psum = {1'b0, cell_p2} + {1'b0, cell_p3};
  assign w_acc  = {32'h0, cell_p1} + {15'h0, w_psum, 16'h0};
  // Only the upper half of acc feeds the hi*hi pass; (p1 << 32) has a zero low word.
  assign w_hi_word = r_acc_hi + cell_p1;

  always_comb begin
    w_state_d = r_state;
    cell_en   = 1'b0;
    w_src1    = r_src1;
    w_src2    = r_src2;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          cell_en   = 1'b1;
          w_src1    = w_win_src1;
          w_src2    = w_win_src2;
          w_state_d = StWait1;
        end
      end
      StWait1: begin
        if (r_op == OP_MULXUU) begin
          cell_en   = 1'b1;
          w_src1    = {16'h0, r_a_hi};
          w_src2    = {16'h0, r_b_hi};
          w_state_d = StWait2;
        end else begin
          w_state_d = StResp;
        end
      end
      StWait2: w_state_d = StResp;
      StResp: begin
        if (rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_op       <= OP_MUL;
      r_id       <= 1'b0;
      r_a_hi     <= 16'h0;
      r_b_hi     <= 16'h0;
      r_acc_hi   <= 32'h0;
      r_rsp_data <= 32'h0;
      r_src1     <= 32'h0;
      r_src2     <= 32'h0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_op   <= req_op[w_win];
        r_id   <= w_win;
        r_a_hi <= w_win_src1[31:16];
        r_b_hi <= w_win_src2[31:16];
      end
      if (cell_en) begin
        r_src1 <= w_src1;
        r_src2 <= w_src2;
      end
      if (r_state == StWait1) begin
        r_acc_hi <= w_acc[63:32];
        if (r_op == OP_MUL) r_rsp_data <= w_acc[31:0];
      end
      if (r_state == StWait2) r_rsp_data <= w_hi_word;
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = (r_state == StResp);
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign cell_src1 = w_src1;
  assign cell_src2 = w_src2;

endmodule

// File: tb/tb_nios_setup_mul_seq_arb.sv
// Directed bench for nios_setup_mul_seq_arb with a behavioural multiplier cell.
module tb_nios_setup_mul_seq_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_valid, req_ready, req_op;
  logic [63:0] req_src1, req_src2;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data, cell_src1, cell_src2;
  logic        cell_en;
  logic [31:0] cell_p1, cell_p2, cell_p3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nios_setup_mul_seq_arb #(
    .INIT_PRIO(1'b0)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_src1 (req_src1),
    .req_src2 (req_src2),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .cell_src1(cell_src1),
    .cell_src2(cell_src2),
    .cell_en  (cell_en),
    .cell_p1  (cell_p1),
    .cell_p2  (cell_p2),
    .cell_p3  (cell_p3)
  );

  // Multiplier cell: one enabled register stage, cleared by the shared reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cell_p1 <= 32'h0;
      cell_p2 <= 32'h0;
      cell_p3 <= 32'h0;
    end else if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          id;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  // Issue one op from an idle DUT and follow it to the response, with rsp_ready high.
  task automatic run_op(input vec_t v);
    int cyc;
    req_op[v.id]          = v.op;
    req_src1[32*v.id +: 32] = v.a;
    req_src2[32*v.id +: 32] = v.b;
    req_valid[v.id]       = 1'b1;
    #1;
    chk("accept_ready", req_ready, (v.id == 1) ? 2'b10 : 2'b01);
    chk("accept_cell_en", cell_en, 1);
    chk("accept_src1", cell_src1, v.a);
    chk("accept_src2", cell_src2, v.b);
    step();
    req_valid = 2'b00;
    cyc = 1;
    while (!rsp_valid && cyc < 8) begin
      chk("wait_cell_en", cell_en, (v.op && cyc == 1));
      chk("wait_ready", req_ready, 0);
      if (v.op && cyc == 1) begin
        chk("hi_src1", cell_src1, {16'h0, v.a[31:16]});
        chk("hi_src2", cell_src2, {16'h0, v.b[31:16]});
      end
      step();
      cyc++;
    end
    chk("latency", cyc, v.op ? 3 : 2);
    chk("rsp_data", rsp_data, v.exp);
    chk("rsp_id", rsp_id, v.id);
    chk("resp_cell_en", cell_en, 0);
    step();
    chk("back_to_idle", rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n_acc, last, exp_idx, cyc;
    reset_n   = 1'b0;
    req_valid = 2'b00;
    req_op    = 2'b00;
    req_src1  = 64'h0;
    req_src2  = 64'h0;
    rsp_ready = 1'b1;

    vecs[0] = '{0, 1'b0, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF};
    vecs[1] = '{1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[2] = '{0, 1'b1, 32'h00010000, 32'h00010000, 32'h00000001};
    vecs[3] = '{1, 1'b0, 32'h00010000, 32'h00010000, 32'h00000000};
    vecs[4] = '{0, 1'b1, 32'h0000FFFF, 32'hFFFFFFFF, 32'h0000FFFE};
    vecs[5] = '{1, 1'b0, 32'h0000FFFF, 32'hFFFFFFFF, 32'hFFFF0001};
    vecs[6] = '{1, 1'b1, 32'h00030002, 32'h00050004, 32'h0000000F};
    vecs[7] = '{0, 1'b0, 32'h00030002, 32'h00050004, 32'h00160008};

    // Reset state
    repeat (2) step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cell_en", cell_en, 0);
    chk("rst_cell_src", {cell_src1, cell_src2}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // Contention: grants alternate from INIT_PRIO, accepts three cycles apart.
    req_op    = 2'b00;
    req_src1  = {32'd5, 32'd2};
    req_src2  = {32'd7, 32'd3};
    req_valid = 2'b11;
    #1;
    n_acc   = 0;
    last    = 0;
    exp_idx = 0;
    for (int c = 0; c < 20 && n_acc < 4; c++) begin
      if (rsp_valid) chk("cont_data", rsp_data, rsp_id ? 35 : 6);
      if (|req_ready) begin
        chk("cont_grant", req_ready, exp_idx ? 2'b10 : 2'b01);
        if (n_acc > 0) chk("cont_gap", c - last, 3);
        last = c;
        n_acc++;
        exp_idx = 1 - exp_idx;
      end
      step();
    end
    chk("cont_count", n_acc, 4);
    req_valid = 2'b00;
    repeat (3) step();

    // Table-driven single ops
    foreach (vecs[i]) run_op(vecs[i]);

    // Response stall with the other requester waiting
    rsp_ready      = 1'b0;
    req_op         = 2'b00;
    req_src1[31:0] = 32'd6;
    req_src2[31:0] = 32'd7;
    req_valid      = 2'b01;
    #1;
    chk("stall_accept", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    cyc = 1;
    while (!rsp_valid && cyc < 8) begin
      step();
      cyc++;
    end
    chk("stall_latency", cyc, 2);
    req_src1[63:32] = 32'd1;
    req_src2[63:32] = 32'd1;
    req_valid       = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, 42);
      chk("stall_id", rsp_id, 0);
      chk("stall_ready", req_ready, 0);
      chk("stall_cell_en", cell_en, 0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("hs_ready", req_ready, 0);
    step();
    chk("resume_ready", req_ready, 2'b10);
    chk("resume_cell_en", cell_en, 1);
    step();
    req_valid = 2'b00;
    cyc = 1;
    while (!rsp_valid && cyc < 8) begin
      step();
      cyc++;
    end
    chk("resume_data", rsp_data, 1);
    chk("resume_id", rsp_id, 1);
    step();

    // Reset during WAIT2 of a req0 MULXUU (pointer moves to 1 on that accept)
    req_op[0]      = 1'b1;
    req_src1[31:0] = 32'hFFFFFFFF;
    req_src2[31:0] = 32'hFFFFFFFF;
    req_valid      = 2'b01;
    #1;
    chk("abort_accept", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    step();
    chk("abort_in_wait2", cell_en, 0);
    req_valid = 2'b11;
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_rsp_id", rsp_id, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_cell_en", cell_en, 0);
    chk("abort_cell_src", {cell_src1, cell_src2}, 0);
    req_valid = 2'b00;
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("abort_no_rsp", rsp_valid, 0);
    end
    req_op    = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("abort_prio", req_ready, 2'b01);
    step();
    req_valid = 2'b00;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
